// File: rtl/pc_seq_pkg.sv
// Shared types and the instruction-length table for the PC sequencer.
// Lengths follow the Y86-64 encoding with a configurable immediate size.
package pc_seq_pkg;

    typedef enum logic [3:0] {
        I_HALT  = 4'h0,
        I_NOP   = 4'h1,
        I_RRMOV = 4'h2,
        I_IRMOV = 4'h3,
        I_RMMOV = 4'h4,
        I_MRMOV = 4'h5,
        I_OPQ   = 4'h6,
        I_JXX   = 4'h7,
        I_CALL  = 4'h8,
        I_RET   = 4'h9,
        I_PUSH  = 4'hA,
        I_POP   = 4'hB
    } icode_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_INS,
        ERR_RAS_OVF,
        ERR_RAS_UNF
    } err_code_t;

    // Invalid codes report length 1 so valp stays meaningful for them.
    function automatic int unsigned instr_len(input logic [3:0] icode,
                                              input int unsigned word_bytes);
        case (icode)
            I_HALT, I_NOP, I_RET:          return 1;
            I_RRMOV, I_OPQ, I_PUSH, I_POP: return 2;
            I_IRMOV, I_RMMOV, I_MRMOV:     return 2 + word_bytes;
            I_JXX, I_CALL:                 return 1 + word_bytes;
            default:                       return 1;
        endcase
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// LIFO of return addresses; reset empties the stack without clearing storage.
// Callers must not push when full or pop when empty.
module return_addr_stack #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  data_in,
    output logic [ADDR_W-1:0]                  top,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     count
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [CW-1:0]     count_q;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     push_idx;

    assign full     = (count_q == CW'(RAS_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign push_idx = IW'(count_q);
    assign top_idx  = IW'(count_q - 1'b1);
    assign top      = empty ? '0 : mem[top_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + 1'b1;
        end else if (pop && !empty) begin
            count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push && !full) begin
            mem[push_idx] <= data_in;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and next-PC selection with call/ret stack and run/halt/error status.
// Once halted or in error only reset brings the sequencer back.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       WORD_BYTES = 8,
    parameter int unsigned       RAS_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [3:0]                      icode_input,
    input  logic                            instr_valid,
    input  logic                            stall,
    input  logic                            cond_true,
    input  logic [ADDR_W-1:0]               valc,
    output logic [ADDR_W-1:0]               pc,
    output logic [ADDR_W-1:0]               valp,
    output logic                            halted,
    output logic                            error,
    output logic [1:0]                      err_code,
    output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_count
);

    state_t            state_q, state_d;
    err_code_t         err_q, err_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ras_push, ras_pop;
    logic              ras_full, ras_empty;
    logic [ADDR_W-1:0] ras_top;

    assign valp     = pc_q + ADDR_W'(instr_len(icode_input, WORD_BYTES));
    assign pc       = pc_q;
    assign halted   = (state_q == ST_HALTED);
    assign error    = (state_q == ST_ERROR);
    assign err_code = err_q;

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock   (clock),
        .reset   (reset),
        .push    (ras_push),
        .pop     (ras_pop),
        .data_in (valp),
        .top     (ras_top),
        .full    (ras_full),
        .empty   (ras_empty),
        .count   (ras_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            err_q   <= ERR_NONE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        pc_d     = pc_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (state_q == ST_RUN && instr_valid && !stall) begin
            case (icode_input)
                I_HALT: state_d = ST_HALTED;
                I_JXX:  pc_d = cond_true ? valc : valp;
                I_CALL: begin
                    if (!ras_full) begin
                        ras_push = 1'b1;
                        pc_d     = valc;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_RAS_OVF;
                    end
                end
                I_RET: begin
                    if (!ras_empty) begin
                        ras_pop = 1'b1;
                        pc_d    = ras_top;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_RAS_UNF;
                    end
                end
                I_NOP, I_RRMOV, I_IRMOV, I_RMMOV, I_MRMOV,
                I_OPQ, I_PUSH, I_POP: pc_d = valp;
                default: begin
                    state_d = ST_ERROR;
                    err_d   = ERR_INS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Two sequencers (reset PC 0x0000 and 0xFFFE) share one stimulus stream and are
// compared each cycle against a behavioural model, plus directed literal checks.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  icode_input = 4'h1;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic        cond_true = 1'b0;
    logic [15:0] valc = '0;

    logic [15:0] pc_o   [2];
    logic [15:0] valp_o [2];
    logic        halted_o [2];
    logic        error_o  [2];
    logic [1:0]  err_o    [2];
    logic [1:0]  cnt_o    [2];

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    pc_sequencer #(
        .ADDR_W(16), .WORD_BYTES(8), .RAS_DEPTH(2), .RESET_PC(16'h0000)
    ) dut0 (
        .clock(clock), .reset(reset), .icode_input(icode_input),
        .instr_valid(instr_valid), .stall(stall), .cond_true(cond_true),
        .valc(valc), .pc(pc_o[0]), .valp(valp_o[0]), .halted(halted_o[0]),
        .error(error_o[0]), .err_code(err_o[0]), .ras_count(cnt_o[0])
    );

    pc_sequencer #(
        .ADDR_W(16), .WORD_BYTES(8), .RAS_DEPTH(2), .RESET_PC(16'hFFFE)
    ) dut1 (
        .clock(clock), .reset(reset), .icode_input(icode_input),
        .instr_valid(instr_valid), .stall(stall), .cond_true(cond_true),
        .valc(valc), .pc(pc_o[1]), .valp(valp_o[1]), .halted(halted_o[1]),
        .error(error_o[1]), .err_code(err_o[1]), .ras_count(cnt_o[1])
    );

    // Reference model: mode 0 run, 1 halted, 2 error; stack as a plain array.
    int unsigned len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    logic [15:0] rst_pc  [2]  = '{16'h0000, 16'hFFFE};
    logic [15:0] m_pc    [2];
    int          m_mode  [2];
    int          m_err   [2];
    logic [15:0] m_stack [2][2];
    int          m_cnt   [2];

    function automatic logic [15:0] model_valp(input int k);
        return m_pc[k] + 16'(len_tab[icode_input]);
    endfunction

    task automatic model_step(input int k);
        logic [15:0] nxt;
        nxt = model_valp(k);
        if (reset) begin
            m_pc[k] = rst_pc[k]; m_mode[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end else if (m_mode[k] == 0 && instr_valid && !stall) begin
            if (icode_input == 4'h0) begin
                m_mode[k] = 1;
            end else if (icode_input == 4'h7) begin
                m_pc[k] = cond_true ? valc : nxt;
            end else if (icode_input == 4'h8) begin
                if (m_cnt[k] < 2) begin
                    m_stack[k][m_cnt[k]] = nxt;
                    m_cnt[k] = m_cnt[k] + 1;
                    m_pc[k] = valc;
                end else begin
                    m_mode[k] = 2; m_err[k] = 2;
                end
            end else if (icode_input == 4'h9) begin
                if (m_cnt[k] > 0) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    m_pc[k] = m_stack[k][m_cnt[k]];
                end else begin
                    m_mode[k] = 2; m_err[k] = 3;
                end
            end else if (icode_input >= 4'hC) begin
                m_mode[k] = 2; m_err[k] = 1;
            end else begin
                m_pc[k] = nxt;
            end
        end
    endtask

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("pc[%0d]", k), 32'(pc_o[k]), 32'(m_pc[k]));
                check($sformatf("valp[%0d]", k), 32'(valp_o[k]), 32'(model_valp(k)));
                check($sformatf("halted[%0d]", k), 32'(halted_o[k]), 32'(m_mode[k] == 1));
                check($sformatf("error[%0d]", k), 32'(error_o[k]), 32'(m_mode[k] == 2));
                check($sformatf("err_code[%0d]", k), 32'(err_o[k]), 32'(m_err[k]));
                check($sformatf("ras_count[%0d]", k), 32'(cnt_o[k]), 32'(m_cnt[k]));
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic s,
                        input logic [3:0] ic, input logic c, input logic [15:0] vc);
        reset = r; instr_valid = v; stall = s; icode_input = ic; cond_true = c; valc = vc;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 16'h0);
    endtask

    task automatic ins(input logic [3:0] ic, input logic c, input logic [15:0] vc);
        step(1'b0, 1'b1, 1'b0, ic, c, vc);
    endtask

    initial begin
        do_reset();
        cmp_en = 1'b1;
        do_reset();
        check("reset pc0", 32'(pc_o[0]), 32'h0000);
        check("reset pc1", 32'(pc_o[1]), 32'hFFFE);
        check("reset status", {halted_o[0], error_o[0], err_o[0], cnt_o[0]}, 32'h0);

        // Straight-line lengths
        ins(4'h1, 1'b0, 16'h0); check("nop pc", 32'(pc_o[0]), 32'h0001);
        ins(4'h3, 1'b0, 16'h0); check("irmov pc", 32'(pc_o[0]), 32'h000B);
        ins(4'h2, 1'b0, 16'h0); check("rrmov pc", 32'(pc_o[0]), 32'h000D);

        // Conditional jumps
        ins(4'h7, 1'b0, 16'h0040); check("jxx not taken", 32'(pc_o[0]), 32'h0016);
        ins(4'h7, 1'b1, 16'h0040); check("jxx taken", 32'(pc_o[0]), 32'h0040);

        // Call / ret
        ins(4'h8, 1'b0, 16'h0100);
        check("call pc", 32'(pc_o[0]), 32'h0100);
        check("call ras", 32'(cnt_o[0]), 32'd1);
        ins(4'h9, 1'b0, 16'h0);
        check("ret pc", 32'(pc_o[0]), 32'h0049);
        check("ret ras", 32'(cnt_o[0]), 32'd0);

        // Stack overflow and underflow
        do_reset();
        ins(4'h8, 1'b0, 16'h0010);
        ins(4'h8, 1'b0, 16'h0020);
        ins(4'h8, 1'b0, 16'h0030);
        check("ovf error", 32'(error_o[0]), 32'd1);
        check("ovf code", 32'(err_o[0]), 32'd2);
        check("ovf pc", 32'(pc_o[0]), 32'h0020);
        check("ovf ras", 32'(cnt_o[0]), 32'd2);
        do_reset();
        ins(4'h9, 1'b0, 16'h0);
        check("unf code", 32'(err_o[0]), 32'd3);

        // Halt freezes pc
        do_reset();
        repeat (5) ins(4'h1, 1'b0, 16'h0);
        check("pre-halt pc", 32'(pc_o[0]), 32'h0005);
        ins(4'h0, 1'b0, 16'h0);
        check("halted", 32'(halted_o[0]), 32'd1);
        repeat (5) ins(4'h1, 1'b0, 16'h0);
        check("halted pc", 32'(pc_o[0]), 32'h0005);
        do_reset();
        check("post-halt pc", 32'(pc_o[0]), 32'h0000);
        check("post-halt flag", 32'(halted_o[0]), 32'd0);

        // Wraparound, stall, invalid code (reset PC 0xFFFE instance)
        icode_input = 4'h3; #1;
        check("valp wrap", 32'(valp_o[1]), 32'h0008);
        ins(4'h3, 1'b0, 16'h0);
        check("wrap pc", 32'(pc_o[1]), 32'h0008);
        repeat (3) step(1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 16'h0);
        check("stall pc", 32'(pc_o[1]), 32'h0008);
        ins(4'hC, 1'b0, 16'h0);
        check("ins code", 32'(err_o[1]), 32'd1);
        check("ins pc", 32'(pc_o[1]), 32'h0008);

        // Randomised traffic with periodic reset to escape terminal states
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] ic;
            int unsigned pick;
            pick = $urandom_range(0, 99);
            if (pick < 3)       ic = 4'h0;
            else if (pick < 6)  ic = 4'(12 + $urandom_range(0, 3));
            else if (pick < 26) ic = 4'h8;
            else if (pick < 46) ic = 4'h9;
            else if (pick < 61) ic = 4'h7;
            else                ic = 4'($urandom_range(1, 11));
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 4) == 0), ic, 1'($urandom_range(0, 1)),
                 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
